// File: rtl/brick_pkg.sv
// brick_pkg: shared constants, palette and counter state type for the
// brick renderer slice.
//   BRICK_W/BRICK_H : brick cell size in pixels
//   COLS/ROWS       : brick grid dimensions
//   NUM_BRICKS      : bricks in the map
//   LEVEL_W         : bits per brick level
//   MAP_W           : width of the packed brick map
//   palette()       : 3-bit level -> 12-bit {R,G,B} colour
package brick_pkg;

  localparam int unsigned BRICK_W    = 32;
  localparam int unsigned BRICK_H    = 20;
  localparam int unsigned COLS       = 20;
  localparam int unsigned ROWS       = 24;
  localparam int unsigned NUM_BRICKS = COLS * ROWS;
  localparam int unsigned LEVEL_W    = 3;
  localparam int unsigned MAP_W      = NUM_BRICKS * LEVEL_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } cnt_state_e;

  function automatic logic [11:0] palette(input logic [LEVEL_W-1:0] level);
    logic [11:0] rgb;
    case (level)
      3'd1:    rgb = 12'hF00;
      3'd2:    rgb = 12'hF80;
      3'd3:    rgb = 12'hFF0;
      3'd4:    rgb = 12'h0F0;
      3'd5:    rgb = 12'h0FF;
      3'd6:    rgb = 12'h00F;
      3'd7:    rgb = 12'hF0F;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/brick_counter.sv
// brick_counter: serial scan of the shadow brick map during vertical blanking.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   snap_i         : frame snapshot strobe; (re)starts a scan at index 0
//   map_i          : shadow brick map (stable for the whole scan)
//   bricks_left_o  : non-zero bricks counted by the last completed scan
//   all_clear_o    : one-cycle pulse when a completed scan counted zero
module brick_counter
  import brick_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snap_i,
  input  logic [MAP_W-1:0] map_i,
  output logic [8:0]       bricks_left_o,
  output logic             all_clear_o
);

  cnt_state_e  state_q;
  logic [8:0]  idx_q;
  logic [8:0]  acc_q;
  logic [8:0]  bricks_left_q;
  logic        all_clear_q;
  logic [10:0] base;
  logic        nonzero;

  assign base    = 11'(idx_q) * 11'(LEVEL_W);
  assign nonzero = |map_i[base +: LEVEL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      bricks_left_q <= '0;
      all_clear_q   <= 1'b0;
    end else begin
      all_clear_q <= 1'b0;
      // A snapshot always wins: it restarts the scan from any state and
      // leaves the published count untouched.
      if (snap_i) begin
        state_q <= SCAN;
        idx_q   <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          IDLE: ;
          SCAN: begin
            if (nonzero) acc_q <= acc_q + 9'd1;
            if (idx_q == 9'(NUM_BRICKS - 1)) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 9'd1;
            end
          end
          DONE: begin
            bricks_left_q <= acc_q;
            all_clear_q   <= (acc_q == '0);
            state_q       <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bricks_left_o = bricks_left_q;
  assign all_clear_o   = all_clear_q;

endmodule

// File: rtl/brick_renderer.sv
// brick_renderer: per-pixel colour generation from a per-frame snapshot of
// the brick map, ball and board, plus a blanking-time brick count.
//   clk, rst_n           : pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt, valid  : VGA pixel position and visible-area flag
//   bricks               : 20x24 brick map, 3 bits per brick
//   ball_x, ball_y       : ball top-left corner
//   board_x              : board left edge
//   pixel_rgb            : {R,G,B} colour, two cycles after h_cnt/v_cnt
//   pixel_valid          : valid delayed by two cycles
//   bricks_left          : non-zero bricks in last completed scan
//   all_clear            : one-cycle pulse when a scan counts zero bricks
// Build option: define BRICK_BORDER_EN to draw a 1-pixel background gap on
// the left column and top line of every brick cell.
module brick_renderer
  import brick_pkg::*;
#(
  parameter int unsigned H       = 640,
  parameter int unsigned V       = 480,
  parameter int unsigned BALL_W  = 16,
  parameter int unsigned BALL_H  = 10,
  parameter int unsigned BOARD_Y = 467,
  parameter int unsigned BOARD_W = 96,
  parameter int unsigned BOARD_H = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic             valid,
  input  logic [MAP_W-1:0] bricks,
  input  logic [9:0]       ball_x,
  input  logic [9:0]       ball_y,
  input  logic [9:0]       board_x,
  output logic [11:0]      pixel_rgb,
  output logic             pixel_valid,
  output logic [8:0]       bricks_left,
  output logic             all_clear
);

  logic snap;
  assign snap = (v_cnt == 10'(V)) && (h_cnt == '0);

  // Frame snapshot
  logic [MAP_W-1:0] map_q;
  logic [9:0]       ball_x_q, ball_y_q, board_x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q     <= '0;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      board_x_q <= '0;
    end else if (snap) begin
      map_q     <= bricks;
      ball_x_q  <= ball_x;
      ball_y_q  <= ball_y;
      board_x_q <= board_x;
    end
  end

  // Stage 1: position decode and sprite hit tests (11-bit, no wrap)
  logic [10:0] h_ext, v_ext;
  logic        ball_hit_d, board_hit_d, in_grid_d;
  logic [4:0]  col_d, row_d;
  logic        ball_hit_q, board_hit_q, in_grid_q, valid_q;
  logic [4:0]  col_q, row_q;

  always_comb begin
    h_ext       = {1'b0, h_cnt};
    v_ext       = {1'b0, v_cnt};
    ball_hit_d  = (h_ext >= {1'b0, ball_x_q}) &&
                  (h_ext <  {1'b0, ball_x_q} + 11'(BALL_W)) &&
                  (v_ext >= {1'b0, ball_y_q}) &&
                  (v_ext <  {1'b0, ball_y_q} + 11'(BALL_H));
    board_hit_d = (h_ext >= {1'b0, board_x_q}) &&
                  (h_ext <  {1'b0, board_x_q} + 11'(BOARD_W)) &&
                  (v_ext >= 11'(BOARD_Y)) &&
                  (v_ext <  11'(BOARD_Y) + 11'(BOARD_H));
    // Row is only meaningful inside the grid, so 5 bits are enough there.
    in_grid_d   = (h_cnt < 10'(H)) && (v_cnt < 10'(V));
    col_d       = 5'(h_cnt / 10'(BRICK_W));
    row_d       = 5'(v_cnt / 10'(BRICK_H));
  end

`ifdef BRICK_BORDER_EN
  logic [4:0] xoff_q, yoff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xoff_q <= '0;
      yoff_q <= '0;
    end else begin
      xoff_q <= 5'(h_cnt % 10'(BRICK_W));
      yoff_q <= 5'(v_cnt % 10'(BRICK_H));
    end
  end
`endif

  // Stage 2: level select, priority and colour
  logic [8:0]         brick_idx;
  logic [10:0]        brick_base;
  logic [LEVEL_W-1:0] level;
  logic               gap;
  logic [11:0]        rgb_d;
  logic [11:0]        rgb_q;
  logic               pixel_valid_q;

  always_comb begin
    brick_idx  = 9'(col_q) + 9'(row_q) * 9'(COLS);
    brick_base = 11'(brick_idx) * 11'(LEVEL_W);
    level      = in_grid_q ? map_q[brick_base +: LEVEL_W] : '0;
`ifdef BRICK_BORDER_EN
    gap        = (xoff_q == '0) || (yoff_q == '0);
`else
    gap        = 1'b0;
`endif
    if (!valid_q)         rgb_d = '0;
    else if (ball_hit_q)  rgb_d = 12'hFFF;
    else if (board_hit_q) rgb_d = 12'h0AF;
    else if (gap)         rgb_d = '0;
    else                  rgb_d = palette(level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_hit_q    <= 1'b0;
      board_hit_q   <= 1'b0;
      in_grid_q     <= 1'b0;
      valid_q       <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      rgb_q         <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      ball_hit_q    <= ball_hit_d;
      board_hit_q   <= board_hit_d;
      in_grid_q     <= in_grid_d;
      valid_q       <= valid;
      col_q         <= col_d;
      row_q         <= row_d;
      rgb_q         <= rgb_d;
      pixel_valid_q <= valid_q;
    end
  end

  assign pixel_rgb   = rgb_q;
  assign pixel_valid = pixel_valid_q;

  brick_counter u_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .snap_i        (snap),
    .map_i         (map_q),
    .bricks_left_o (bricks_left),
    .all_clear_o   (all_clear)
  );

endmodule

// File: doc/brick_renderer.md
# brick_renderer

Pixel-side reader of the game state that the ball/physics logic writes each frame. It sits between the VGA timing counters and the RGB output pins. It snapshots the 480-entry brick map, ball position and board position once per frame, then emits one 12-bit colour per pixel through a two-stage pipeline. During vertical blanking it also scans the snapshot serially and reports the number of bricks remaining plus a level-cleared pulse.

## Interface
- H, 640, visible width in pixels
- V, 480, visible height in lines
- BALL_W, 16, ball width
- BALL_H, 10, ball height
- BOARD_Y, 467, board top line
- BOARD_W, 96, board width
- BOARD_H, 10, board height
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous and active-low
- h_cnt  in  10  current pixel column from the VGA controller
- v_cnt  in  10  current pixel line from the VGA controller
- valid  in  1  high inside the visible area
- bricks  in  1440  brick map: 20 columns by 24 rows, 3 bits per brick
- ball_x, ball_y  in  10 each  ball top-left corner
- board_x  in  10  board left edge
- pixel_rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- pixel_valid  out  1  `valid` delayed by 2 cycles
- bricks_left  out  9  count of non-zero bricks in the last completed scan
- all_clear  out  1  one-cycle pulse when a scan completes with a count of 0

## Operation
- **Brick indexing.** Brick (c,r) occupies bits [3c+60r +: 3], with c = x/32 and r = y/20. Level 0 means empty; levels 1–7 are looked up in the palette.
- **Snapshot.**
  - A snapshot event (`snap`) occurs on the cycle where v_cnt==V and h_cnt==0.
  - On `snap`, bricks, ball_x, ball_y and board_x are copied into shadow registers.
  - All rendering and scanning use only the shadow copies, so there is no tearing within a frame.
- **Pixel pipeline.**
  - Stage 1 registers the column (h_cnt[9:5]), row (v_cnt/20), in-brick offsets (h_cnt[4:0], v_cnt%20), the ball-hit and board-hit flags, and valid.
  - Stage 2 selects the 3-bit level, applies priority, and registers pixel_rgb and pixel_valid.
  - Priority: ball (12'hFFF) > board (12'h0AF) > brick palette[level] > background (12'h000).
  - Ball hit: ball_x ≤ h < ball_x+BALL_W and ball_y ≤ v < ball_y+BALL_H.
  - Board hit: board_x ≤ h < board_x+BOARD_W and BOARD_Y ≤ v < BOARD_Y+BOARD_H.
  - All comparisons use 11-bit sums, so a right or bottom edge beyond 1023 does not wrap.
  - When the registered valid is 0, pixel_rgb is 0.
- **Counter FSM (brick_counter).**
  - IDLE → SCAN on `snap`: the index and accumulator are cleared.
  - SCAN: reads one brick per cycle at index 0..479 and increments the accumulator when the level is non-zero.
  - SCAN → DONE after index 479.
  - DONE (one cycle): bricks_left ← accumulator; all_clear ← (accumulator==0); then → IDLE.
  - A `snap` arriving in SCAN or DONE restarts the scan at index 0 without updating bricks_left.
- **Reset.** Every output, shadow register and pipeline register is 0, and the FSM is in IDLE. all_clear never fires before the first completed scan.

## Timing
- pixel_rgb and pixel_valid at cycle t+2 correspond to h_cnt/v_cnt/valid at cycle t. There is no stall path.
- The shadow update is visible to stage 1 on the cycle after `snap`.
- A scan takes 480 SCAN cycles plus 1 DONE cycle. bricks_left updates 482 cycles after `snap`, well inside the 45-line blanking interval.
- all_clear is high for exactly one cycle, in the cycle after DONE is entered.
- Asserting rst_n low mid-scan aborts the scan immediately. bricks_left goes to 0.

## Configuration
- BRICK_BORDER_EN
  - Defined: brick pixels with x offset 0 or y offset 0 inside their cell are drawn as background, giving a 1-pixel grid gap.
  - Undefined: bricks are solid 32×20 cells.
  - Ball/board priority and counting are unaffected either way.

## Structure
- Package brick_pkg holds:
  - constants BRICK_W=32, BRICK_H=20, COLS=20, ROWS=24, NUM_BRICKS=480, LEVEL_W=3;
  - the 8-entry 12-bit palette (0:000, 1:F00, 2:F80, 3:FF0, 4:0F0, 5:0FF, 6:00F, 7:F0F);
  - the FSM state enum {IDLE, SCAN, DONE}.
- Sub-module brick_counter holds the scan FSM. It is fed by the shadow brick map and `snap`.

## Test plan
- **Reset.** Hold rst_n=0 with valid=1 → pixel_rgb=0, pixel_valid=0, bricks_left=0, all_clear=0.
- **Single brick.** Brick (c=2,r=1) set to level 1, all others 0; snap; drive h=70, v=25 → two cycles later pixel_rgb=12'hF00. h=70, v=45 → 12'h000.
- **Priority.** Ball at (64,20) over a level-4 brick; board_x=100. Pixel (70,25) → 12'hFFF. Pixel (120,470) → 12'h0AF.
- **Tearing.** Change the bricks input mid-frame without a snap → rendered colours are unchanged until the next snap.
- **Counting.** Full map at level 1 → bricks_left=480 after 482 cycles. Snap with an all-zero map → bricks_left=0 and a single all_clear pulse.
- **Border.** With BRICK_BORDER_EN defined, brick (0,0) at level 2, pixel (0,5) → 12'h000 and pixel (1,5) → 12'hF80. With the macro undefined, pixel (0,5) → 12'hF80.
